io_axi_uart_regs: RTL and testbench

AXI4-Lite register responder for the core's IN/OUT port. It sits between the core's 4-bit-address S_AXI initiator and a byte-serial UART PHY (separate rx/tx blocks). A 16-entry RX FIFO and a 16-entry TX FIFO buffer bytes in each direction. The register map is UART-Lite style: RX data, TX data, status, control.

---
 rtl/io_axi_uart_regs.sv | 242 ++++++++++++++++++++++++
 tb/tb_io_axi_uart_regs.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_axi_uart_regs.sv
// Synchronous FIFO with pointer-based full/empty and a combinational head read.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; flush empties it and beats both.
module uart_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push_vld & ~full & ~flush;
    assign do_pop   = pop_vld & ~empty & ~flush;
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

// AXI4-Lite UART-Lite style register block with RX/TX byte FIFOs.
// Latency: write response one cycle after AW+W complete; read data one cycle after AR.
// Backpressure: AW/W/AR stall while a response is pending; RX_READY drops when RX is full.
module io_axi_uart_regs #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  S_AXI_AWADDR,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTB,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [3:0]  S_AXI_ARADDR,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY
);
    localparam logic [1:0] REG_RXD     = 2'd0;
    localparam logic [1:0] REG_TXD     = 2'd1;
    localparam logic [1:0] REG_STAT    = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic       aw_held;
    logic       w_held;
    logic [1:0] aw_addr_q;
    logic [7:0] w_dat_q;
    logic       w_stb_q;
    logic       tx_overrun;

    logic       aw_hs;
    logic       w_hs;
    logic       ar_hs;
    logic       wr_fire;
    logic [1:0] wr_addr;
    logic [7:0] wr_dat;
    logic       wr_stb;
    logic       txd_wr;
    logic       tx_push;
    logic       tx_drop;
    logic       ctrl_wr;
    logic       tx_flush;
    logic       rx_flush;
    logic       ovr_clr;
    logic [1:0] rd_addr;

    logic       rx_push;
    logic       rx_pop;
    logic [7:0] rx_head;
    logic       rx_full;
    logic       rx_empty;
    logic       tx_pop;
    logic [7:0] tx_head;
    logic       tx_full;
    logic       tx_empty;
    logic [31:0] stat_word;
    logic       unused_bits;

    assign unused_bits = ^{S_AXI_WDATA[31:8], S_AXI_WSTB[3:1], S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Write channel: AW and W are held independently; the write fires as soon as both are present.
    assign S_AXI_AWREADY = ~aw_held & ~S_AXI_BVALID;
    assign S_AXI_WREADY  = ~w_held & ~S_AXI_BVALID;
    assign aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs    = S_AXI_WVALID & S_AXI_WREADY;
    assign wr_fire = (aw_held | aw_hs) & (w_held | w_hs);
    assign wr_addr = aw_held ? aw_addr_q : S_AXI_AWADDR[3:2];
    assign wr_dat  = w_held ? w_dat_q : S_AXI_WDATA[7:0];
    assign wr_stb  = w_held ? w_stb_q : S_AXI_WSTB[0];

    assign txd_wr   = wr_fire & (wr_addr == REG_TXD) & wr_stb;
    assign tx_push  = txd_wr & ~tx_full;
    assign tx_drop  = txd_wr & tx_full;
    assign ctrl_wr  = wr_fire & (wr_addr == REG_CTRL);
    assign tx_flush = ctrl_wr & wr_dat[0];
    assign rx_flush = ctrl_wr & wr_dat[1];
    assign ovr_clr  = ctrl_wr & wr_dat[4];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_addr_q    <= 2'd0;
            w_dat_q      <= 8'd0;
            w_stb_q      <= 1'b0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
            tx_overrun   <= 1'b0;
        end else begin
            if (wr_fire) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= tx_drop ? RESP_SLVERR : RESP_OKAY;
            end else begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= S_AXI_AWADDR[3:2];
                end
                if (w_hs) begin
                    w_held  <= 1'b1;
                    w_dat_q <= S_AXI_WDATA[7:0];
                    w_stb_q <= S_AXI_WSTB[0];
                end
                if (S_AXI_BVALID & S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
            end
            if (tx_drop)      tx_overrun <= 1'b1;
            else if (ovr_clr) tx_overrun <= 1'b0;
        end
    end

    // Read channel: status is sampled from the registered FIFO flags at the AR handshake.
    assign S_AXI_ARREADY = ~S_AXI_RVALID;
    assign ar_hs     = S_AXI_ARVALID & S_AXI_ARREADY;
    assign rd_addr   = S_AXI_ARADDR[3:2];
    assign rx_pop    = ar_hs & (rd_addr == REG_RXD) & ~rx_empty;
    assign stat_word = {27'd0, tx_overrun, tx_full, tx_empty, rx_full, ~rx_empty};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= 32'd0;
            S_AXI_RRESP  <= RESP_OKAY;
        end else if (ar_hs) begin
            S_AXI_RVALID <= 1'b1;
            case (rd_addr)
                REG_RXD: begin
                    S_AXI_RDATA <= rx_empty ? 32'd0 : {24'd0, rx_head};
                    S_AXI_RRESP <= rx_empty ? RESP_SLVERR : RESP_OKAY;
                end
                REG_STAT: begin
                    S_AXI_RDATA <= stat_word;
                    S_AXI_RRESP <= RESP_OKAY;
                end
                default: begin
                    S_AXI_RDATA <= 32'd0;
                    S_AXI_RRESP <= RESP_OKAY;
                end
            endcase
        end else if (S_AXI_RVALID & S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
        end
    end

    assign RX_READY = ~rx_full;
    assign rx_push  = RX_VALID & RX_READY;

    uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .flush    (rx_flush),
        .push_vld (rx_push),
        .push_dat (RX_DATA),
        .pop_vld  (rx_pop),
        .head_dat (rx_head),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    assign TX_VALID = ~tx_empty;
    assign TX_DATA  = tx_empty ? 8'd0 : tx_head;
    assign tx_pop   = TX_VALID & TX_READY;

    uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .flush    (tx_flush),
        .push_vld (tx_push),
        .push_dat (S_AXI_WDATA[7:0] & {8{~w_held}} | w_dat_q & {8{w_held}}),
        .pop_vld  (tx_pop),
        .head_dat (tx_head),
        .full     (tx_full),
        .empty    (tx_empty)
    );
endmodule

// File: tb/tb_io_axi_uart_regs.sv
// Directed bench for io_axi_uart_regs: register map, FIFO boundaries, handshakes and reset abort.
module tb_io_axi_uart_regs;
    logic        CLK;
    logic        RST;
    logic [3:0]  S_AXI_AWADDR;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        RX_READY;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    logic [31:0] rd;
    logic [1:0]  rsp;

    io_axi_uart_regs #(.FIFO_DEPTH(16)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTB    (S_AXI_WSTB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .RX_DATA       (RX_DATA),
        .RX_VALID      (RX_VALID),
        .RX_READY      (RX_READY),
        .TX_DATA       (TX_DATA),
        .TX_VALID      (TX_VALID),
        .TX_READY      (TX_READY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] stb, output logic [1:0] resp);
        logic aw_done;
        logic w_done;
        logic aw_now;
        logic w_now;
        logic seen;
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_WSTB    = stb;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        aw_done = 1'b0;
        w_done  = 1'b0;
        for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
            aw_now = S_AXI_AWREADY & S_AXI_AWVALID;
            w_now  = S_AXI_WREADY & S_AXI_WVALID;
            step();
            if (aw_now) begin aw_done = 1'b1; S_AXI_AWVALID = 1'b0; end
            if (w_now)  begin w_done = 1'b1;  S_AXI_WVALID = 1'b0; end
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b1;
        seen = 1'b0;
        resp = 2'b11;
        for (int n = 0; n < 20 && !seen; n++) begin
            if (S_AXI_BVALID) begin
                seen = 1'b1;
                resp = S_AXI_BRESP;
            end
            step();
        end
        S_AXI_BREADY = 1'b0;
        chk("bvalid_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
        logic ar_done;
        logic ar_now;
        logic seen;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        ar_done = 1'b0;
        for (int n = 0; n < 20 && !ar_done; n++) begin
            ar_now = S_AXI_ARREADY;
            step();
            if (ar_now) ar_done = 1'b1;
        end
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;
        seen = 1'b0;
        data = 32'hDEAD_BEEF;
        resp = 2'b11;
        for (int n = 0; n < 20 && !seen; n++) begin
            if (S_AXI_RVALID) begin
                seen = 1'b1;
                data = S_AXI_RDATA;
                resp = S_AXI_RRESP;
            end
            step();
        end
        S_AXI_RREADY = 1'b0;
        chk("rvalid_seen", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        RST = 1'b1;
        S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = 32'h0; S_AXI_WSTB = 4'h0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = 4'h0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        RX_DATA = 8'h0; RX_VALID = 1'b0; TX_READY = 1'b0;
        step();
        step();

        // Reset values
        chk("rst_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
        chk("rst_wready",  {31'd0, S_AXI_WREADY},  32'd1);
        chk("rst_arready", {31'd0, S_AXI_ARREADY}, 32'd1);
        chk("rst_rxready", {31'd0, RX_READY},      32'd1);
        chk("rst_bvalid",  {31'd0, S_AXI_BVALID},  32'd0);
        chk("rst_rvalid",  {31'd0, S_AXI_RVALID},  32'd0);
        chk("rst_txvalid", {31'd0, TX_VALID},      32'd0);
        chk("rst_txdata",  {24'd0, TX_DATA},       32'd0);
        chk("rst_rdata",   S_AXI_RDATA,            32'd0);
        chk("rst_bresp",   {30'd0, S_AXI_BRESP},   32'd0);
        RST = 1'b0;
        step();

        axi_read(4'h8, rd, rsp);
        chk("idle_stat", rd, 32'h0000_0004);
        chk("idle_stat_resp", {30'd0, rsp}, 32'd0);

        // Two TX bytes drain in order once the transmitter is ready
        axi_write(4'h4, 32'h41, 4'h1, rsp);
        chk("tx41_resp", {30'd0, rsp}, 32'd0);
        axi_write(4'h4, 32'h42, 4'h1, rsp);
        chk("tx42_resp", {30'd0, rsp}, 32'd0);
        chk("tx_head_41", {24'd0, TX_DATA}, 32'h41);
        chk("tx_valid_held", {31'd0, TX_VALID}, 32'd1);
        TX_READY = 1'b1;
        step();
        chk("tx_head_42", {24'd0, TX_DATA}, 32'h42);
        chk("tx_valid_2nd", {31'd0, TX_VALID}, 32'd1);
        step();
        chk("tx_drained", {31'd0, TX_VALID}, 32'd0);
        TX_READY = 1'b0;

        // Fill TX to overflow
        for (int i = 0; i < 17; i++) begin
            axi_write(4'h4, 32'h60 + i, 4'h1, rsp);
            chk("txfill_resp", {30'd0, rsp}, (i < 16) ? 32'd0 : 32'd2);
        end
        chk("txfull_head", {24'd0, TX_DATA}, 32'h60);
        axi_read(4'h8, rd, rsp);
        chk("stat_overrun", rd, 32'h0000_0018);
        axi_write(4'hC, 32'h10, 4'hF, rsp);
        chk("ctrl_clr_resp", {30'd0, rsp}, 32'd0);
        axi_read(4'h8, rd, rsp);
        chk("stat_ovr_cleared", rd, 32'h0000_0008);
        axi_write(4'hC, 32'h01, 4'hF, rsp);
        axi_read(4'h8, rd, rsp);
        chk("stat_tx_flushed", rd, 32'h0000_0004);
        chk("tx_valid_flushed", {31'd0, TX_VALID}, 32'd0);

        // TXD write with strobe bit 0 low does not push
        axi_write(4'h4, 32'h99, 4'hE, rsp);
        chk("txd_nostb_resp", {30'd0, rsp}, 32'd0);
        chk("txd_nostb_empty", {31'd0, TX_VALID}, 32'd0);

        // Fill RX
        for (int i = 0; i < 16; i++) begin
            RX_DATA  = i[7:0];
            RX_VALID = 1'b1;
            step();
        end
        chk("rx_ready_full", {31'd0, RX_READY}, 32'd0);
        RX_DATA = 8'hAA;
        step();
        RX_VALID = 1'b0;
        axi_read(4'h8, rd, rsp);
        chk("stat_rx_full", rd, 32'h0000_0007);
        for (int i = 0; i < 16; i++) begin
            axi_read(4'h0, rd, rsp);
            chk("rxd_data", rd, i);
            chk("rxd_resp", {30'd0, rsp}, 32'd0);
        end
        axi_read(4'h0, rd, rsp);
        chk("rxd_empty_data", rd, 32'd0);
        chk("rxd_empty_resp", {30'd0, rsp}, 32'd2);
        chk("rx_ready_empty", {31'd0, RX_READY}, 32'd1);

        // RX flush through CTRL
        RX_DATA = 8'h33; RX_VALID = 1'b1;
        step();
        step();
        RX_VALID = 1'b0;
        axi_read(4'h8, rd, rsp);
        chk("stat_rx_two", rd, 32'h0000_0005);
        axi_write(4'hC, 32'h02, 4'hF, rsp);
        axi_read(4'h8, rd, rsp);
        chk("stat_rx_flushed", rd, 32'h0000_0004);

        // W three cycles ahead of AW, BREADY held low
        S_AXI_WDATA = 32'h55; S_AXI_WSTB = 4'h1; S_AXI_WVALID = 1'b1;
        step();
        S_AXI_WVALID = 1'b0;
        chk("w_held_wready", {31'd0, S_AXI_WREADY}, 32'd0);
        chk("w_held_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
        step();
        step();
        chk("w_held_no_b", {31'd0, S_AXI_BVALID}, 32'd0);
        chk("w_held_no_push", {31'd0, TX_VALID}, 32'd0);
        S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1;
        step();
        S_AXI_AWVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bhold_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
            chk("bhold_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
            chk("bhold_wready", {31'd0, S_AXI_WREADY}, 32'd0);
            step();
        end
        chk("bhold_bresp", {30'd0, S_AXI_BRESP}, 32'd0);
        chk("bhold_txdata", {24'd0, TX_DATA}, 32'h55);
        S_AXI_BREADY = 1'b1;
        step();
        S_AXI_BREADY = 1'b0;
        chk("bhold_released", {31'd0, S_AXI_BVALID}, 32'd0);
        axi_read(4'h8, rd, rsp);
        chk("stat_one_tx", rd, 32'h0000_0000);
        TX_READY = 1'b1;
        step();
        TX_READY = 1'b0;
        chk("one_push_only", {31'd0, TX_VALID}, 32'd0);

        // Reset during a pending read
        RX_DATA = 8'h99; RX_VALID = 1'b1;
        step();
        RX_VALID = 1'b0;
        axi_write(4'h4, 32'h77, 4'h1, rsp);
        S_AXI_ARADDR = 4'h8; S_AXI_ARVALID = 1'b1;
        step();
        S_AXI_ARVALID = 1'b0;
        chk("pend_rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
        chk("pend_rdata", S_AXI_RDATA, 32'h0000_0001);
        chk("pend_arready", {31'd0, S_AXI_ARREADY}, 32'd0);
        step();
        chk("pend_rvalid_held", {31'd0, S_AXI_RVALID}, 32'd1);
        RST = 1'b1;
        #1;
        chk("arst_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
        chk("arst_txvalid", {31'd0, TX_VALID}, 32'd0);
        chk("arst_arready", {31'd0, S_AXI_ARREADY}, 32'd1);
        step();
        RST = 1'b0;
        step();
        axi_read(4'h8, rd, rsp);
        chk("post_rst_stat", rd, 32'h0000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
